dts_split_samples: RTL
======================

Name: dts_split_samples

Overview:
- Transmit-side inverse of the DTS sample builder: accepts parallel ADC samples in 12-bit lanes and packs them into 3 concatenated 128-bit streams ("top", "middle", "bottom") for the DTS formatter.
- Sits between the test-pattern/ADC capture path and the DTS framer.
- Supports 3-bit mode (bitwise split across all three streams) and 8-bit mode (bytes alternated between top and bottom, middle zero).
- Accumulates input beats into an output word, with valid/ready handshakes on both sides.

Parameters:
- OUTPUT_WIDTH, 128, width of each stream; must be a multiple of 8*LANES.
- LANES, 8, 12-bit samples per input beat.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- is_three_bit  in  1  1 = 3-bit mode, 0 = 8-bit mode; sampled only at word start.
- din  in  12*LANES  samples, earliest in the MSB lane.
- din_valid  in  1  input beat valid.
- din_ready  out  1  block accepts a beat this cycle.
- flush  in  1  one-cycle pulse: emit a partial word zero-padded.
- dout  out  3*OUTPUT_WIDTH  {top, middle, bottom}, earliest sample in the MSBs.
- dout_valid  out  1  dout holds a complete word.
- dout_ready  in  1  downstream accepts dout.
- word_mode  out  1  value of is_three_bit latched for the word on dout.

Behaviour:
- Reset (async, rst_n=0) clears the following: dout=0, dout_valid=0, word_mode=0, beat counter=0, accumulator=0, mode latch=0. din_ready=1 after reset.
- A beat transfers when din_valid && din_ready. An output word transfers when dout_valid && dout_ready.
- Mode latch: is_three_bit is captured on the first beat of each word (counter==0). Changes mid-word are ignored until the next word.
- Beats per word:
  - 3-bit mode: NB3 = OUTPUT_WIDTH/LANES (16 at defaults).
  - 8-bit mode: NB8 = OUTPUT_WIDTH/(4*LANES) (4 at defaults).
- Within a word, k is the sample index (0 = earliest, across beats; MSB lane first within a beat).
- 3-bit mapping: the sample is lane[11:9].
  - bit 2 -> top[OUTPUT_WIDTH-1-k]
  - bit 1 -> middle[OUTPUT_WIDTH-1-k]
  - bit 0 -> bottom[OUTPUT_WIDTH-1-k]
- 8-bit mapping: the byte is lane[11:4] (truncation); lane[3:0] is discarded.
  - Even k goes to the top stream, odd k to the bottom stream.
  - Byte slot j = OUTPUT_WIDTH/8-1-(k>>1); the byte occupies bits [8j+7:8j].
  - Middle stream = 0.
- Double buffering: one accumulator plus one output register.
  - On the final beat, the accumulator moves to dout and dout_valid is set on the next cycle. Latency from final-beat acceptance to dout_valid is 1 cycle.
  - The counter wraps to 0 and the accumulator clears.
- din_ready = !(counter==last && dout_valid && !dout_ready). Only the final beat stalls, and only while the output register is occupied and not draining. A final beat and an output drain in the same cycle proceed together with no bubble.
- Flush:
  - If counter>0, the partial word moves to dout on the same terms as a final beat. Unfilled positions are 0. The counter resets.
  - If counter==0, flush is a no-op.
  - Flush coinciding with an accepted beat: the beat is included first, then the word is emitted.
  - Flush while dout is blocked: held pending until the output register frees. din_ready=0 while pending.
- dout, word_mode and dout_valid are stable while dout_valid && !dout_ready.
- Reset asserted mid-word or mid-stall discards all data immediately; no partial word is emitted.

Optional Feature:
- Macro: DTS_SPLIT_ROUND_EN.
- When defined, the 8-bit-mode byte = lane[11:4] + lane[3], round half up, saturating at 0xFF.
- The 3-bit byte path is identical, with rounding done on lane[11:9] + lane[8], saturating at 7.
- When undefined, plain truncation as above. Adds no latency either way.

Test Plan:
- 3-bit mode, 16 beats with all lanes 12'hE00 (sample=7), dout_ready=1 -> one cycle after beat 16: dout_valid=1, dout = all ones (384'h…FF), word_mode=1.
- 8-bit mode, 4 beats with samples 0x010,0x020,…,0x200 (k=0..31), no rounding -> top[127:120]=8'h01, bottom[127:120]=8'h02, top[7:0]=8'h1F, bottom[7:0]=8'h20, middle=0.
- Backpressure: dout_ready=0 while a second word's last beat arrives -> din_ready=0 only on that beat. Raise dout_ready -> first word transfers and second word appears the next cycle with no data loss.
- Mode toggled after beat 2 of a 3-bit word -> word completes after 16 beats as 3-bit. Next word uses the new mode (4 beats).
- 3-bit mode, 3 beats then flush -> dout_valid next cycle. Samples 0..23 are placed in top/middle/bottom bits 127..104; all other bits are 0. Counter restarts.
- Reset asserted after 2 beats -> dout_valid=0, dout=0. A subsequent fresh word is built from its first beat; with DTS_SPLIT_ROUND_EN, sample 0x018 -> byte 0x02, sample 0xFF8 -> byte 0xFF.

Source files
------------

// File: rtl/dts_split_samples.sv
// dts_split_samples: transmit-side sample packer for the DTS formatter.
// Accepts beats of LANES x 12-bit ADC samples and builds one word made of three
// OUTPUT_WIDTH-bit streams {top, middle, bottom}. In 3-bit mode the top three
// sample bits are spread bitwise across the streams. In 8-bit mode bytes
// alternate between top and bottom, and middle stays zero.
// Optional build macro DTS_SPLIT_ROUND_EN: round half up with saturation when a
// sample is reduced to 8 or 3 bits, instead of plain truncation.
module dts_split_samples #(
    parameter int OUTPUT_WIDTH = 128,
    parameter int LANES        = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      is_three_bit,
    input  logic [12*LANES-1:0]       din,
    input  logic                      din_valid,
    output logic                      din_ready,
    input  logic                      flush,
    output logic [3*OUTPUT_WIDTH-1:0] dout,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic                      word_mode
);

    localparam int NB3 = OUTPUT_WIDTH / LANES;
    localparam int NB8 = OUTPUT_WIDTH / (4 * LANES);
    localparam int CW  = $clog2(NB3 + 1);
    localparam int IW  = $clog2(OUTPUT_WIDTH);
    localparam logic [CW-1:0] LAST3 = CW'(NB3 - 1);
    localparam logic [CW-1:0] LAST8 = CW'(NB8 - 1);

`ifdef DTS_SPLIT_ROUND_EN
    localparam logic RND = 1'b1;
`else
    localparam logic RND = 1'b0;
`endif

    // s = sample[11:3]; the guard bit s[0] only matters when rounding
    function automatic logic [7:0] f_byte(input logic [8:0] s);
        logic [8:0] sum;
        sum = {1'b0, s[8:1]} + {8'd0, s[0] & RND};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // s = sample[11:8]; the guard bit s[0] only matters when rounding
    function automatic logic [2:0] f_bits3(input logic [3:0] s);
        logic [3:0] sum;
        sum = {1'b0, s[3:1]} + {3'd0, s[0] & RND};
        return sum[3] ? 3'd7 : sum[2:0];
    endfunction

    logic [CW-1:0]           r_cnt;
    logic                    r_mode;
    logic                    r_flush_pend;
    logic [OUTPUT_WIDTH-1:0] r_acc_top;
    logic [OUTPUT_WIDTH-1:0] r_acc_mid;
    logic [OUTPUT_WIDTH-1:0] r_acc_bot;
    logic [3*OUTPUT_WIDTH-1:0] r_dout;
    logic                    r_dout_valid;
    logic                    r_word_mode;

    logic                    w_mode;
    logic                    w_at_last;
    logic                    w_out_free;
    logic                    w_beat;
    logic                    w_flush_req;
    logic                    w_has_data;
    logic                    w_emit;
    logic [OUTPUT_WIDTH-1:0] w_top;
    logic [OUTPUT_WIDTH-1:0] w_mid;
    logic [OUTPUT_WIDTH-1:0] w_bot;
    logic                    w_unused_din;

    // The low sample bits below the rounding guard never reach the streams
    assign w_unused_din = ^din;

    // Mode of the word being built: live input on its first beat, latch after
    assign w_mode      = (r_cnt == '0) ? is_three_bit : r_mode;
    assign w_at_last   = (r_cnt == (w_mode ? LAST3 : LAST8));
    assign w_out_free  = !r_dout_valid || dout_ready;
    assign din_ready   = !(w_at_last && r_dout_valid && !dout_ready) && !r_flush_pend;
    assign w_beat      = din_valid && din_ready;
    assign w_flush_req = flush || r_flush_pend;
    assign w_has_data  = (r_cnt != '0) || w_beat;
    assign w_emit      = ((w_beat && w_at_last) || (w_flush_req && w_has_data)) && w_out_free;

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign word_mode  = r_word_mode;

    // Accumulator contents after inserting the current beat (if one transfers)
    always_comb begin
        logic [11:0]   v_smp;
        logic [2:0]    v_b3;
        logic [7:0]    v_b8;
        logic [IW-1:0] v_pos;
        logic [IW-1:0] v_base;
        int            v_k;
        w_top  = r_acc_top;
        w_mid  = r_acc_mid;
        w_bot  = r_acc_bot;
        v_smp  = '0;
        v_b3   = '0;
        v_b8   = '0;
        v_pos  = '0;
        v_base = '0;
        v_k    = 0;
        if (w_beat) begin
            for (int l = 0; l < LANES; l++) begin
                v_smp = din[12*(LANES-l)-1 -: 12];
                v_k   = int'(r_cnt) * LANES + l;
                if (w_mode) begin
                    v_b3  = f_bits3(v_smp[11:8]);
                    v_pos = IW'(OUTPUT_WIDTH - 1 - v_k);
                    w_top[v_pos] = v_b3[2];
                    w_mid[v_pos] = v_b3[1];
                    w_bot[v_pos] = v_b3[0];
                end else begin
                    v_b8   = f_byte(v_smp[11:3]);
                    v_base = IW'(8 * (OUTPUT_WIDTH/8 - 1 - (v_k >> 1)));
                    if ((v_k % 2) == 0) begin
                        w_top[v_base +: 8] = v_b8;
                    end else begin
                        w_bot[v_base +: 8] = v_b8;
                    end
                end
            end
        end
    end

    // Beat counter, mode latch, accumulator, output register and pending flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_mode       <= 1'b0;
            r_flush_pend <= 1'b0;
            r_acc_top    <= '0;
            r_acc_mid    <= '0;
            r_acc_bot    <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_word_mode  <= 1'b0;
        end else begin
            // A flush that cannot move its word yet waits for the output register
            r_flush_pend <= w_flush_req && w_has_data && !w_out_free;
            if (w_beat && (r_cnt == '0)) begin
                r_mode <= is_three_bit;
            end
            if (w_emit) begin
                r_dout       <= {w_top, w_mid, w_bot};
                r_word_mode  <= w_mode;
                r_dout_valid <= 1'b1;
                r_cnt        <= '0;
                r_acc_top    <= '0;
                r_acc_mid    <= '0;
                r_acc_bot    <= '0;
            end else begin
                if (dout_ready) begin
                    r_dout_valid <= 1'b0;
                end
                if (w_beat) begin
                    r_cnt     <= r_cnt + CW'(1);
                    r_acc_top <= w_top;
                    r_acc_mid <= w_mid;
                    r_acc_bot <= w_bot;
                end
            end
        end
    end

endmodule
